// File: rtl/password_check.sv
// Password comparator with timed unlock window and lockout alarm after three
// consecutive wrong entries.
module password_check #(
  parameter int OPEN_CYCLES = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] npw_6,
  input  logic       status,
  input  logic [5:0] ipw_6,
  input  logic       Check,
  output logic       unlock,
  output logic       fail,
  output logic [1:0] err_cnt,
  output logic       alarm
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OPEN  = 2'd1;
  localparam logic [1:0] ALARM = 2'd2;

  localparam logic [7:0] OPEN_LOAD = 8'(OPEN_CYCLES - 1);
  localparam logic [7:0] LOCK_LOAD = 8'(LOCK_CYCLES - 1);

  logic [1:0] r_state;
  logic [7:0] r_timer;
  logic       r_checkD;
  logic       r_block;
  logic       r_unlock;
  logic       r_fail;
  logic [1:0] r_errCnt;
  logic       r_alarm;

  logic       w_chk;
  logic       w_match;

  // r_block suppresses a Check level that was already high during reset, so
  // only a genuine rising edge after reset release counts as a confirm.
  assign w_chk   = Check & ~r_checkD & ~r_block;
  assign w_match = (ipw_6 == npw_6);

  assign unlock  = r_unlock;
  assign fail    = r_fail;
  assign err_cnt = r_errCnt;
  assign alarm   = r_alarm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= 8'd0;
      r_checkD <= 1'b0;
      r_block  <= Check;
      r_unlock <= 1'b0;
      r_fail   <= 1'b0;
      r_errCnt <= 2'd0;
      r_alarm  <= 1'b0;
    end else begin
      r_checkD <= Check;
      r_block  <= r_block & Check;
      r_fail   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_chk && !status) begin
            if (w_match) begin
              r_state  <= OPEN;
              r_timer  <= OPEN_LOAD;
              r_unlock <= 1'b1;
              r_errCnt <= 2'd0;
            end else if (r_errCnt == 2'd2) begin
              r_state  <= ALARM;
              r_timer  <= LOCK_LOAD;
              r_alarm  <= 1'b1;
              r_errCnt <= 2'd3;
              r_fail   <= 1'b1;
            end else begin
              r_errCnt <= r_errCnt + 2'd1;
              r_fail   <= 1'b1;
            end
          end
        end
        // Entering set mode closes the lock immediately.
        OPEN: begin
          if (status || (r_timer == 8'd0)) begin
            r_state  <= IDLE;
            r_timer  <= 8'd0;
            r_unlock <= 1'b0;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        ALARM: begin
          if (r_timer == 8'd0) begin
            r_state  <= IDLE;
            r_alarm  <= 1'b0;
            r_errCnt <= 2'd0;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_timer  <= 8'd0;
          r_unlock <= 1'b0;
          r_alarm  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/password_check.md
PASSWORD_CHECK -- requirements
Module: password_check

Interface
REQ-001 Parameter OPEN_CYCLES, default 8: cycles the lock stays open after a correct entry; legal range 1..255.
REQ-002 Parameter LOCK_CYCLES, default 16: cycles of alarm lockout after the third consecutive failure; legal range 1..255.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 npw_6  input  6  stored password from the upstream password-set stage; stable while status=0.
REQ-006 status  input  1  upstream set-mode flag; 1 = password being edited.
REQ-007 ipw_6  input  6  password entered by the user.
REQ-008 Check  input  1  user "confirm" level; only its rising edge triggers a comparison.
REQ-009 unlock  output  1  registered; 1 while the lock is open.
REQ-010 fail  output  1  registered; one-cycle pulse on each rejected entry.
REQ-011 err_cnt  output  2  registered; consecutive failure count, 0..3.
REQ-012 alarm  output  1  registered; 1 during lockout.

Function
REQ-013 Edge detect: Check is registered into Check_d each cycle; chk = Check & ~Check_d; a level held high produces exactly one chk.
REQ-014 FSM states: IDLE, OPEN, ALARM; one-cycle timer, 8 bits wide.
REQ-015 IDLE, chk, status=0, ipw_6==npw_6 -> OPEN at that edge; unlock=1 from the next cycle; timer loads OPEN_CYCLES-1; err_cnt clears to 0.
REQ-016 IDLE, chk, status=0, ipw_6!=npw_6, err_cnt<2 -> stay IDLE; err_cnt increments; fail=1 for exactly one cycle.
REQ-017 IDLE, chk, status=0, mismatch, err_cnt==2 -> ALARM; err_cnt=3; fail=1 for one cycle; alarm=1 from the next cycle; timer loads LOCK_CYCLES-1.
REQ-018 OPEN: timer decrements each cycle; at timer==0 -> IDLE; unlock is high for exactly OPEN_CYCLES cycles.
REQ-019 OPEN: chk is ignored and has no effect on the timer or on err_cnt.
REQ-020 ALARM: timer decrements each cycle; at timer==0 -> IDLE with err_cnt=0; alarm is high for exactly LOCK_CYCLES cycles.
REQ-021 ALARM: chk and status are ignored; set mode cannot bypass lockout.
REQ-022 status=1 in IDLE: chk is ignored; no fail; err_cnt holds.
REQ-023 status=1 in OPEN: immediate return to IDLE on the next edge; unlock=0; err_cnt holds.
REQ-024 A chk coinciding with a state's timer-expiry cycle is discarded, not queued.
REQ-025 Comparison is a full 6-bit equality using the npw_6 value sampled on the chk cycle.
REQ-026 unlock and alarm are never both 1.
REQ-027 fail is never 1 while unlock=1.

Reset
REQ-028 rst=1 at a rising edge forces: state=IDLE, timer=0, Check_d=0, unlock=0, fail=0, err_cnt=0, alarm=0.
REQ-029 rst takes priority over every other input, including mid-OPEN and mid-ALARM.
REQ-030 First chk is recognised only on a rising Check edge after rst deasserts; Check held high through reset does not trigger.

Verification
REQ-031 npw_6=6'b101010, ipw_6=6'b101010, one Check pulse -> unlock=1 for 8 cycles, err_cnt=0, fail never asserts.
REQ-032 npw_6=6'b101010, ipw_6=6'b000111, three separate Check pulses -> fail pulses 3 times, err_cnt 1,2,3, alarm=1 for 16 cycles, then err_cnt=0.
REQ-033 Two mismatches then ipw_6=6'b101010 -> err_cnt 1,2 then 0; unlock=1; no alarm.
REQ-034 Check held high for 20 cycles with mismatch -> exactly one fail pulse and err_cnt=1.
REQ-035 Correct entry, then status=1 on the 3rd open cycle -> unlock=0 next cycle; a Check pulse while status=1 produces no response.
REQ-036 rst asserted on the 5th alarm cycle -> all outputs 0 next cycle; a correct entry afterwards opens the lock normally.
